// File: rtl/fpu_vector_checker.sv
// fpu_vector_checker: the consumer end of the FPU sample-vector flow.
// It takes (operand, expected) pairs over a valid/ready stream and drives each
// operand into the unit under test. The expected value is delayed to line up
// with the unit's fixed latency and compared with the unit's result. The
// checker counts vectors and errors and captures the first failing vector.
// Optional build macro: VCHK_STOP_ON_FAIL_EN. When it is defined, the first
// mismatch stops intake and the run drains straight to DONE.
module fpu_vector_checker #(
    parameter int OP_W  = 32,
    parameter int RES_W = 1,
    parameter int LAT   = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [RES_W-1:0] in_exp,
    input  logic             in_last,
    output logic [OP_W-1:0]  dut_op,
    input  logic [RES_W-1:0] dut_res,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [OP_W-1:0]  fail_op,
    output logic [RES_W-1:0] fail_exp,
    output logic [RES_W-1:0] fail_got,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t r_state;
    state_t w_state_next;

    logic             w_ready;
    logic             w_accept;
    logic             w_run_entry;
    logic             w_cmp;
    logic             w_mismatch;
    logic             w_stop;

    logic [OP_W-1:0]  r_dut_op;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [OP_W-1:0]  r_fail_op;
    logic [RES_W-1:0] r_fail_exp;
    logic [RES_W-1:0] r_fail_got;
    logic             r_fail_seen;

    // Alignment pipe. Stage 0 is loaded on the same edge as dut_op, and
    // stage LAT (the tail) is where dut_res is valid for that operand.
    logic             r_pipe_vld [0:LAT];
    logic [OP_W-1:0]  r_pipe_op  [0:LAT];
    logic [RES_W-1:0] r_pipe_exp [0:LAT];

    // w_any[k] is 1 when any of stages 0..k-1 holds a vector. w_any[LAT] shows
    // whether anything is left once the tail has been compared.
    logic [LAT:0]     w_any;

    assign w_any[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_any
            assign w_any[gi+1] = w_any[gi] | r_pipe_vld[gi];
        end
    endgenerate

    assign w_accept    = in_valid && w_ready;
    assign w_run_entry = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cmp       = r_pipe_vld[LAT];
    assign w_mismatch  = w_cmp && (dut_res != r_pipe_exp[LAT]);

`ifdef VCHK_STOP_ON_FAIL_EN
    // Any mismatch closes intake in the same cycle it is seen.
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A start pulse in RUN or DRAIN is ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_stop || (w_accept && in_last)) w_state_next = S_DRAIN;
            S_DRAIN: if (!w_any[LAT]) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        case (r_state)
            S_RUN: begin
                w_ready = !w_stop;
                busy    = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = (r_err_cnt == '0);
            end
            default: ;
        endcase
    end

    assign in_ready = w_ready;

    // Operand register toward the unit. It holds between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dut_op <= '0;
        end else if (w_accept) begin
            r_dut_op <= in_op;
        end
    end

    // Pipe valid bits shift every cycle, so back-to-back accepts leave no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) r_pipe_vld[i] <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            for (int i = 1; i <= LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    // The pipe payload needs no reset because it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pipe_op[0]  <= in_op;
            r_pipe_exp[0] <= in_exp;
        end
        for (int i = 1; i <= LAT; i++) begin
            r_pipe_op[i]  <= r_pipe_op[i-1];
            r_pipe_exp[i] <= r_pipe_exp[i-1];
        end
    end

    // Statistics: cleared on entry to RUN and updated at the tail compare point.
    // The counters saturate at their maximum value.
    always_ff @(posedge clk) begin
        if (rst || w_run_entry) begin
            r_vec_cnt   <= '0;
            r_err_cnt   <= '0;
            r_fail_op   <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_cmp) begin
            if (r_vec_cnt != CNT_MAX) r_vec_cnt <= r_vec_cnt + CNT_ONE;
            if (w_mismatch) begin
                if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
                if (!r_fail_seen) begin
                    r_fail_op   <= r_pipe_op[LAT];
                    r_fail_exp  <= r_pipe_exp[LAT];
                    r_fail_got  <= dut_res;
                    r_fail_seen <= 1'b1;
                end
            end
        end
    end

    assign dut_op   = r_dut_op;
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign fail_op  = r_fail_op;
    assign fail_exp = r_fail_exp;
    assign fail_got = r_fail_got;

endmodule
